adsr_envelope_gen: RTL and testbench

// - Parametrised ADSR (attack/decay/sustain/release) envelope shaper for PWM note amplitudes.
// - Successor to the attack/release-only envelope generator:
//   - runtime-programmable rates and sustain level
//   - gate edge retrigger
//   - status outputs
// - Sits between the note/tone generator (duty_i) and the PWM modulator (duty_o).

---
 rtl/adsr_envelope_gen_if.sv | 25 ++
 rtl/adsr_envelope_gen.sv | 102 ++++++++++
 tb/tb_adsr_envelope_gen.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/adsr_envelope_gen_if.sv
// adsr_envelope_gen_if: gate, rate/sustain controls, duty path and status of adsr_envelope_gen
interface adsr_envelope_gen_if #(
    parameter int BW = 24,
    parameter int ENV_W = 8,
    parameter int RATE_W = 8
);
    logic              gate_i;
    logic [RATE_W-1:0] attack_rate_i;
    logic [RATE_W-1:0] decay_rate_i;
    logic [ENV_W-1:0]  sustain_lvl_i;
    logic [RATE_W-1:0] release_rate_i;
    logic [BW-1:0]     duty_i;
    logic [BW-1:0]     duty_o;
    logic [ENV_W-1:0]  env_level_o;
    logic [2:0]        state_o;
    logic              busy_o;
    modport master (
        output gate_i, attack_rate_i, decay_rate_i, sustain_lvl_i, release_rate_i, duty_i,
        input  duty_o, env_level_o, state_o, busy_o
    );
    modport slave (
        input  gate_i, attack_rate_i, decay_rate_i, sustain_lvl_i, release_rate_i, duty_i,
        output duty_o, env_level_o, state_o, busy_o
    );
endinterface

// File: rtl/adsr_envelope_gen.sv
// adsr_envelope_gen: ADSR envelope shaper scaling a PWM duty word by the envelope level.
// Define ADSR_EXP_RELEASE_EN for an exponential-like release (decrement max(1, level>>3)).
module adsr_envelope_gen #(
    parameter int BW = 24,
    parameter int ENV_W = 8,
    parameter int RATE_W = 8
) (
    input logic clk_i,
    input logic rst_i,
    adsr_envelope_gen_if.slave bus
);
    localparam logic [ENV_W-1:0] ENV_MAX = '1;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;
    state_t            state, state_n;
    logic [ENV_W-1:0]  level, level_n, rel_dec;
    logic [RATE_W-1:0] rate_cnt, cnt_n, rate_sel, cnt_adv;
    logic [BW-1:0]     duty_q, duty_n;
    logic              gate_q, rise, fall, step;
    assign rise = bus.gate_i & ~gate_q;
    assign fall = ~bus.gate_i & gate_q;
    assign rate_sel = (state == ATTACK) ? bus.attack_rate_i :
                      (state == DECAY)  ? bus.decay_rate_i  : bus.release_rate_i;
    assign step = rate_cnt >= rate_sel;
    assign cnt_adv = step ? '0 : rate_cnt + 1'b1;
`ifdef ADSR_EXP_RELEASE_EN
    assign rel_dec = ((level >> 3) == '0) ? ENV_W'(1) : (level >> 3);
`else
    assign rel_dec = ENV_W'(1);
`endif
    assign duty_n = BW'(((BW+ENV_W)'(bus.duty_i) * (BW+ENV_W)'(level)) >> ENV_W);
    always_comb begin
        state_n = state;
        level_n = level;
        cnt_n = '0;
        if (rise) begin
            state_n = ATTACK;
        end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            state_n = RELEASE;
        end else begin
            case (state)
                ATTACK: begin
                    cnt_n = cnt_adv;
                    if (step) begin
                        level_n = (level == ENV_MAX) ? ENV_MAX : level + 1'b1;
                        state_n = (level >= ENV_MAX - 1'b1) ? DECAY : ATTACK;
                    end
                end
                DECAY: begin
                    // sustain check precedes the rate step so a high sustain is entered at once
                    if (level <= bus.sustain_lvl_i) begin
                        level_n = bus.sustain_lvl_i;
                        state_n = SUSTAIN;
                    end else begin
                        cnt_n = cnt_adv;
                        if (step) level_n = level - 1'b1;
                    end
                end
                SUSTAIN: level_n = bus.sustain_lvl_i;
                RELEASE: begin
                    if (level == '0) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt_adv;
                        if (step) begin
                            level_n = (level > rel_dec) ? level - rel_dec : '0;
                            state_n = (level > rel_dec) ? RELEASE : IDLE;
                        end
                    end
                end
                default: begin
                    level_n = '0;
                    state_n = IDLE;
                end
            endcase
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            level <= '0;
            rate_cnt <= '0;
            gate_q <= 1'b0;
            duty_q <= '0;
        end else begin
            state <= state_n;
            level <= level_n;
            rate_cnt <= cnt_n;
            gate_q <= bus.gate_i;
            duty_q <= duty_n;
        end
    end
    assign bus.duty_o = duty_q;
    assign bus.env_level_o = level;
    assign bus.state_o = state;
    assign bus.busy_o = state != IDLE;
endmodule

// File: tb/tb_adsr_envelope_gen.sv
// tb_adsr_envelope_gen: directed ADSR scenarios checked every cycle against a behavioural envelope model.
module tb_adsr_envelope_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int m_state, m_lvl, m_cnt, m_duty;
    bit m_gq;
    int pats [5][7] = '{
        '{1, 2, 100, 1, 600, 200, 24'hFFFFFF},
        '{0, 3, 200, 5, 300, 100, 24'h123456},
        '{2, 0, 0, 0, 50, 30, 24'h800000},
        '{0, 0, 255, 0, 300, 300, 24'h00ABCD},
        '{1, 1, 50, 3, 20, 10, 24'h7FFFFF}
    };
    adsr_envelope_gen_if #(.BW(24), .ENV_W(8), .RATE_W(8)) bus();
    adsr_envelope_gen #(.BW(24), .ENV_W(8), .RATE_W(8)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // Envelope model: phase numbers follow the state_o encoding, cnt counts cycles since the last step
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_lvl = 0; m_cnt = 0; m_gq = 0; m_duty = 0;
        end else begin : model
            int rate, dec, sus;
            bit due, rise, fall;
            m_duty = int'((longint'(bus.duty_i) * longint'(m_lvl)) >> 8);
            rise = bus.gate_i && !m_gq;
            fall = !bus.gate_i && m_gq;
            m_gq = bus.gate_i;
            sus = int'(bus.sustain_lvl_i);
            rate = m_state == 1 ? int'(bus.attack_rate_i) : m_state == 2 ? int'(bus.decay_rate_i) : int'(bus.release_rate_i);
            due = m_cnt >= rate;
`ifdef ADSR_EXP_RELEASE_EN
            dec = (m_lvl / 8 < 1) ? 1 : m_lvl / 8;
`else
            dec = 1;
`endif
            if (rise) begin
                m_state = 1; m_cnt = 0;
            end else if (fall && m_state >= 1 && m_state <= 3) begin
                m_state = 4; m_cnt = 0;
            end else begin
                case (m_state)
                    1: if (due) begin
                        m_lvl = (m_lvl + 1 > 255) ? 255 : m_lvl + 1;
                        if (m_lvl == 255) m_state = 2;
                    end
                    2: if (m_lvl <= sus) begin
                        m_lvl = sus; m_state = 3;
                    end else if (due) m_lvl = m_lvl - 1;
                    3: m_lvl = sus;
                    4: if (m_lvl == 0) m_state = 0;
                       else if (due) begin
                        m_lvl = (m_lvl - dec < 0) ? 0 : m_lvl - dec;
                        if (m_lvl == 0) m_state = 0;
                    end
                    default: m_lvl = 0;
                endcase
                m_cnt = ((m_state == 1 || m_state == 2 || m_state == 4) && !due) ? m_cnt + 1 : 0;
            end
        end
    end
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("model_level", bus.env_level_o, m_lvl);
            chk("model_state", bus.state_o, m_state);
            chk("model_busy", bus.busy_o, m_state != 0);
            chk("model_duty", bus.duty_o, m_duty);
        end
    end
    initial begin
        bus.gate_i = 0; bus.attack_rate_i = 0; bus.decay_rate_i = 0;
        bus.sustain_lvl_i = 128; bus.release_rate_i = 0; bus.duty_i = 24'h100000;
        step_n(2);
        chk("reset_duty", bus.duty_o, 0);
        chk("reset_level", bus.env_level_o, 0);
        chk("reset_state", bus.state_o, 0);
        chk("reset_busy", bus.busy_o, 0);
        rst = 0;
        cmp_en = 1;
        bus.gate_i = 1;
        step_n(256);
        chk("attack_peak_level", bus.env_level_o, 255);
        chk("attack_peak_state", bus.state_o, 2);
        step_n(1);
        chk("full_scale_duty", bus.duty_o, 24'h0FF000);
        step_n(126);
        chk("decay_end_level", bus.env_level_o, 128);
        step_n(1);
        chk("sustain_state", bus.state_o, 3);
        chk("sustain_level", bus.env_level_o, 128);
        bus.sustain_lvl_i = 64;
        step_n(1);
        chk("sustain_track_64", bus.env_level_o, 64);
        bus.sustain_lvl_i = 128;
        step_n(1);
        chk("sustain_track_128", bus.env_level_o, 128);
        bus.gate_i = 0;
        step_n(1);
        chk("pulse_release_state", bus.state_o, 4);
        chk("pulse_release_level", bus.env_level_o, 128);
        bus.gate_i = 1;
        step_n(1);
        chk("retrigger_state", bus.state_o, 1);
        chk("retrigger_no_click", bus.env_level_o >= 127 && bus.env_level_o <= 128, 1);
        #2 rst = 1;
        #1;
        chk("async_rst_duty", bus.duty_o, 0);
        chk("async_rst_level", bus.env_level_o, 0);
        chk("async_rst_state", bus.state_o, 0);
        chk("async_rst_busy", bus.busy_o, 0);
        bus.gate_i = 0;
        step_n(1);
        rst = 0;
        bus.attack_rate_i = 3;
        bus.gate_i = 1;
        step_n(20);
        chk("attack3_level", bus.env_level_o, 4);
        bus.gate_i = 0;
        step_n(1);
        chk("fall_state", bus.state_o, 4);
        chk("fall_level", bus.env_level_o, 4);
        step_n(3);
        chk("release_level_1", bus.env_level_o, 1);
        step_n(1);
        chk("release_idle_state", bus.state_o, 0);
        chk("release_idle_level", bus.env_level_o, 0);
        chk("release_idle_busy", bus.busy_o, 0);
`ifdef ADSR_EXP_RELEASE_EN
        bus.attack_rate_i = 0;
        bus.gate_i = 1;
        step_n(256);
        chk("exp_peak", bus.env_level_o, 255);
        bus.gate_i = 0;
        step_n(1);
        chk("exp_enter_release", bus.state_o, 4);
        step_n(1);
        chk("exp_step1", bus.env_level_o, 224);
        step_n(1);
        chk("exp_step2", bus.env_level_o, 196);
        step_n(1);
        chk("exp_step3", bus.env_level_o, 172);
        for (int i = 0; i < 300 && bus.state_o != 0; i++) step_n(1);
        chk("exp_idle_state", bus.state_o, 0);
        chk("exp_idle_level", bus.env_level_o, 0);
`endif
        for (int p = 0; p < 5; p++) begin
            bus.attack_rate_i = 8'(pats[p][0]);
            bus.decay_rate_i = 8'(pats[p][1]);
            bus.sustain_lvl_i = 8'(pats[p][2]);
            bus.release_rate_i = 8'(pats[p][3]);
            bus.duty_i = 24'(pats[p][6]);
            bus.gate_i = 1;
            step_n(pats[p][4]);
            bus.gate_i = 0;
            step_n(pats[p][5]);
        end
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
